// File: rtl/contador_pkg.sv
// Shared types and constants for the contador_regresivo down-counter/timer.
package contador_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_t;

  localparam int unsigned WIDTH_DEF = 3;

endpackage

// File: rtl/contador_regresivo.sv
// Loadable down-counter/timer with a one-cycle terminal-count pulse.
// Optional feature: define CONTADOR_AUTO_RELOAD_EN to restart automatically
// from the last loaded value after each terminal count.
module contador_regresivo
  import contador_pkg::*;
#(
  parameter int unsigned WIDTH = WIDTH_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic             enable,
  output logic [WIDTH-1:0] count,
  output logic             busy,
  output logic             done,
  output logic             zero
);

  state_t           state, state_nxt;
  logic [WIDTH-1:0] count_q, count_nxt;

`ifdef CONTADOR_AUTO_RELOAD_EN
  logic [WIDTH-1:0] reload_q, reload_nxt;

  // Reload register: remembers the value of the last accepted load
  always_ff @(posedge clk or posedge reset) begin
    if (reset) reload_q <= '0;
    else       reload_q <= reload_nxt;
  end
`endif

  // State and count registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      count_q <= '0;
    end else begin
      state   <= state_nxt;
      count_q <= count_nxt;
    end
  end

  // Next-state and next-count logic; load overrides everything else
  always_comb begin
    state_nxt  = state;
    count_nxt  = count_q;
`ifdef CONTADOR_AUTO_RELOAD_EN
    reload_nxt = reload_q;
`endif
    if (load) begin
      count_nxt = load_value;
      state_nxt = (load_value != '0) ? RUN : DONE;
`ifdef CONTADOR_AUTO_RELOAD_EN
      reload_nxt = load_value;
`endif
    end else begin
      case (state)
        RUN: begin
          if (enable) begin
            if (count_q > WIDTH'(1)) begin
              count_nxt = count_q - WIDTH'(1);
            end else begin
              count_nxt = '0;
              state_nxt = DONE;
            end
          end
        end
        DONE: begin
`ifdef CONTADOR_AUTO_RELOAD_EN
          if (reload_q != '0) begin
            count_nxt = reload_q;
            state_nxt = RUN;
          end else begin
            count_nxt = '0;
            state_nxt = IDLE;
          end
`else
          count_nxt = '0;
          state_nxt = IDLE;
`endif
        end
        default: begin
          state_nxt = IDLE;
        end
      endcase
    end
  end

  // Output decode from registered state and count
  always_comb begin
    count = count_q;
    busy  = (state == RUN);
    done  = (state == DONE);
    zero  = (count_q == '0);
  end

endmodule
